// File: rtl/fd_pipe_latch_nwide.sv
// N-wide fetch/decode pipeline register with prefix-qualified per-slot valids,
// valid/ready handshake, synchronous flush, saturating stall counter and an
// optional skid entry enabled by defining FD_PIPE_LATCH_SKID_EN.
module fd_pipe_latch_nwide #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned COMMON_W = 66,
  parameter int unsigned LANE_W   = 30,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [LANES-1:0]          in_lane_en,
  input  logic [COMMON_W-1:0]       in_common,
  input  logic [LANES*LANE_W-1:0]   in_lane,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [COMMON_W-1:0]       out_common,
  output logic [LANES*LANE_W-1:0]   out_lane,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic                    r_out_valid;
  logic [LANES-1:0]        r_lane_valid;
  logic [COMMON_W-1:0]     r_common;
  logic [LANES*LANE_W-1:0] r_lane;
  logic [CNT_W-1:0]        r_stall_cnt;

  logic [LANES-1:0]        w_mask;
  logic                    w_main_free;
  logic                    w_release;
  logic                    w_hold;
  logic                    w_accept;
  logic                    w_accept_main;

  // Slot k is live only when every lower slot is enabled too.
  always_comb begin
    w_mask    = '0;
    w_mask[0] = in_lane_en[0];
    for (int unsigned k = 1; k < LANES; k++) begin
      w_mask[k] = w_mask[k-1] & in_lane_en[k];
    end
  end

  assign w_main_free = ~r_out_valid | out_ready;
  assign w_release   = r_out_valid & out_ready;
  assign w_hold      = r_out_valid & ~out_ready;
  assign w_accept    = in_valid & in_ready;

`ifdef FD_PIPE_LATCH_SKID_EN
  logic                    r_skid_valid;
  logic [LANES-1:0]        r_skid_lane_valid;
  logic [COMMON_W-1:0]     r_skid_common;
  logic [LANES*LANE_W-1:0] r_skid_lane;
  logic                    r_in_ready;
  logic                    w_accept_skid;
  logic                    w_load_skid;

  assign in_ready      = r_in_ready;
  assign w_accept_main = w_accept & w_main_free;
  assign w_accept_skid = w_accept & ~w_main_free;
  assign w_load_skid   = w_main_free & r_skid_valid;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_skid_valid      <= 1'b0;
      r_skid_lane_valid <= '0;
      r_skid_common     <= '0;
      r_skid_lane       <= '0;
      r_in_ready        <= 1'b1;
    end else if (flush) begin
      r_skid_valid      <= 1'b0;
      r_skid_lane_valid <= '0;
      r_in_ready        <= 1'b1;
    end else if (w_load_skid) begin
      r_skid_valid      <= 1'b0;
      r_skid_lane_valid <= '0;
      r_in_ready        <= 1'b1;
    end else if (w_accept_skid) begin
      r_skid_valid      <= 1'b1;
      r_skid_lane_valid <= w_mask;
      r_skid_common     <= in_common;
      r_in_ready        <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (w_mask[k]) begin
          r_skid_lane[k*LANE_W +: LANE_W] <= in_lane[k*LANE_W +: LANE_W];
        end
      end
    end
  end
`else
  assign in_ready      = w_main_free;
  assign w_accept_main = w_accept;
`endif

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_out_valid  <= 1'b0;
      r_lane_valid <= '0;
      r_common     <= '0;
      r_lane       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_lane_valid <= '0;
`ifdef FD_PIPE_LATCH_SKID_EN
    end else if (w_load_skid) begin
      // Only slots valid in the skid overwrite main, so masked-off slots keep
      // their previous main payload exactly as a direct accept would.
      r_out_valid  <= 1'b1;
      r_lane_valid <= r_skid_lane_valid;
      r_common     <= r_skid_common;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (r_skid_lane_valid[k]) begin
          r_lane[k*LANE_W +: LANE_W] <= r_skid_lane[k*LANE_W +: LANE_W];
        end
      end
`endif
    end else if (w_accept_main) begin
      r_out_valid  <= 1'b1;
      r_lane_valid <= w_mask;
      r_common     <= in_common;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (w_mask[k]) begin
          r_lane[k*LANE_W +: LANE_W] <= in_lane[k*LANE_W +: LANE_W];
        end
      end
    end else if (w_release) begin
      r_out_valid  <= 1'b0;
      r_lane_valid <= '0;
    end
  end

  // Counts hold cycles regardless of flush; only reset clears it.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_stall_cnt <= '0;
    end else if (w_hold && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid      = r_out_valid;
  assign out_lane_valid = r_lane_valid;
  assign out_common     = r_common;
  assign out_lane       = r_lane;
  assign stall_cnt      = r_stall_cnt;

endmodule
